read_packer: RTL and testbench

READ_PACKER -- requirements
Module: read_packer

---
 rtl/read_packer_pkg.sv | 19 +
 rtl/read_packer_ascii_to_sym.sv | 18 +
 rtl/read_packer.sv | 136 +++++++++++++
 tb/tb_read_packer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_packer_pkg.sv
// Shared symbol definitions for the read-alignment datapath: 2-bit bases plus N,
// each carried in a 4-bit symbol slot, and the read-id width.
package BwaMemDefines;
    localparam int RID_W = 32;

    typedef logic [3:0] Symbol;

    localparam Symbol SYM_A = 4'd0;
    localparam Symbol SYM_C = 4'd1;
    localparam Symbol SYM_G = 4'd2;
    localparam Symbol SYM_T = 4'd3;
    localparam Symbol SYM_N = 4'd4;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_DRAIN,
        ST_HOLD
    } pack_state_e;
endpackage

// File: rtl/read_packer_ascii_to_sym.sv
// One byte lane of ASCII-to-symbol encoding; combinational, case-insensitive,
// anything that is not A/C/G/T maps to N.
module ascii_to_sym
    import BwaMemDefines::*;
(
    input  logic [7:0] byte_i,
    output Symbol      sym_o
);
    always_comb begin
        case (byte_i)
            8'h41, 8'h61: sym_o = SYM_A;
            8'h43, 8'h63: sym_o = SYM_C;
            8'h47, 8'h67: sym_o = SYM_G;
            8'h54, 8'h74: sym_o = SYM_T;
            default:      sym_o = SYM_N;
        endcase
    end
endmodule

// File: rtl/read_packer.sv
// Packs an ASCII base stream into one fixed-length symbol word per read, tagged with a read id.
// Word is presented one cycle after the tlast beat; input is stalled while a word waits for m_axis_tready.
module read_packer
    import BwaMemDefines::*;
#(
    parameter int  READ_LEN = 76,
    parameter int  IN_BYTES = 8,
    localparam int READ_DW  = READ_LEN*4 + RID_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_BYTES*8-1:0] s_axis_tdata,
    input  logic [IN_BYTES-1:0]   s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [READ_DW-1:0]    m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic [RID_W-1:0]      rid_base,
    input  logic                  param_update,
    output logic [31:0]           stat_trunc_cnt,
    output logic [31:0]           stat_short_cnt
);
    localparam int PW = $clog2(READ_LEN + 1);

    pack_state_e      state_q;
    logic [PW-1:0]    pos_q, pos_d;
    Symbol            syms_q [READ_LEN];
    Symbol            syms_d [READ_LEN];
    logic [RID_W-1:0] rid_q;
    logic             trunc_q;
    logic [31:0]      trunc_cnt_q, short_cnt_q;

    Symbol       enc [IN_BYTES];
    logic [15:0] pop, sum;
    logic        accept, trunc_now, short_now;

    for (genvar k = 0; k < IN_BYTES; k++) begin : g_lane
        ascii_to_sym u_enc (
            .byte_i (s_axis_tdata[k*8 +: 8]),
            .sym_o  (enc[k])
        );
    end

    assign s_axis_tready  = (state_q != ST_HOLD);
    assign m_axis_tvalid  = (state_q == ST_HOLD);
    assign accept         = s_axis_tvalid && s_axis_tready;
    assign stat_trunc_cnt = trunc_cnt_q;
    assign stat_short_cnt = short_cnt_q;

    always_comb begin
        pop = '0;
        for (int k = 0; k < IN_BYTES; k++) begin
            pop = pop + 16'(s_axis_tkeep[k]);
        end
        sum       = 16'(pos_q) + pop;
        pos_d     = (sum >= 16'(READ_LEN)) ? PW'(READ_LEN) : PW'(sum);
        // In DRAIN the word is already full, so any kept byte overflows it.
        trunc_now = ((state_q == ST_FILL) && (sum > 16'(READ_LEN))) ||
                    ((state_q == ST_DRAIN) && (pop != 16'd0));
        short_now = (state_q == ST_FILL) && (sum < 16'(READ_LEN));
    end

    // Lane k lands on symbol pos+k; lanes past the end of the read find no symbol.
    always_comb begin
        for (int i = 0; i < READ_LEN; i++) begin
            syms_d[i] = syms_q[i];
            for (int k = 0; k < IN_BYTES; k++) begin
                if (s_axis_tkeep[k] && (16'(i) == 16'(pos_q) + 16'(k))) begin
                    syms_d[i] = enc[k];
                end
            end
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        for (int i = 0; i < READ_LEN; i++) begin
            m_axis_tdata[i*4 +: 4] = syms_q[i];
        end
        m_axis_tdata[READ_LEN*4 +: RID_W] = rid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            pos_q       <= '0;
            rid_q       <= '0;
            trunc_q     <= 1'b0;
            trunc_cnt_q <= '0;
            short_cnt_q <= '0;
            for (int i = 0; i < READ_LEN; i++) syms_q[i] <= SYM_N;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        syms_q <= syms_d;
                        pos_q  <= pos_d;
                        if (trunc_now) trunc_q <= 1'b1;
                        if (s_axis_tlast) begin
                            state_q <= ST_HOLD;
                            if (trunc_now && trunc_cnt_q != '1) trunc_cnt_q <= trunc_cnt_q + 32'd1;
                            if (short_now && short_cnt_q != '1) short_cnt_q <= short_cnt_q + 32'd1;
                        end else if (sum >= 16'(READ_LEN)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept) begin
                        if (trunc_now) trunc_q <= 1'b1;
                        if (s_axis_tlast) begin
                            state_q <= ST_HOLD;
                            if ((trunc_q || trunc_now) && trunc_cnt_q != '1) begin
                                trunc_cnt_q <= trunc_cnt_q + 32'd1;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (m_axis_tready) begin
                        state_q <= ST_FILL;
                        pos_q   <= '0;
                        trunc_q <= 1'b0;
                        rid_q   <= rid_q + 1'b1;
                        for (int i = 0; i < READ_LEN; i++) syms_q[i] <= SYM_N;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
            // A reload overrides the post-handshake increment.
            if (param_update) rid_q <= rid_base;
        end
    end
endmodule

// File: tb/tb_read_packer.sv
// Directed bench for read_packer: hand-built reads, expected words assembled from per-symbol tables.
module tb_read_packer;
    import BwaMemDefines::*;

    localparam int READ_LEN = 76;
    localparam int READ_DW  = READ_LEN*4 + RID_W;
    localparam int BOUND    = 2000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [63:0]        s_axis_tdata = '0;
    logic [7:0]         s_axis_tkeep = '0;
    logic               s_axis_tvalid = 1'b0;
    logic               s_axis_tready;
    logic               s_axis_tlast = 1'b0;
    logic [READ_DW-1:0] m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready = 1'b0;
    logic [RID_W-1:0]   rid_base = '0;
    logic               param_update = 1'b0;
    logic [31:0]        stat_trunc_cnt, stat_short_cnt;

    read_packer dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .rid_base       (rid_base),
        .param_update   (param_update),
        .stat_trunc_cnt (stat_trunc_cnt),
        .stat_short_cnt (stat_short_cnt)
    );

    always #5 clk = ~clk;

    int                 vectors = 0;
    int                 miscompares = 0;
    logic [7:0]         rd_buf [256];
    logic [3:0]         exp_sym [READ_LEN];
    int                 stall_cnt = 0;
    logic [READ_DW-1:0] word;
    logic [READ_DW-1:0] ew [3];
    int                 unst = 0;
    int                 hold_viol = 0;

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [READ_DW-1:0] mk(input logic [RID_W-1:0] rid);
        logic [READ_DW-1:0] w;
        w = '0;
        for (int i = 0; i < READ_LEN; i++) w[i*4 +: 4] = exp_sym[i];
        w[READ_LEN*4 +: RID_W] = rid;
        return w;
    endfunction

    task automatic send_buf(input int n);
        int          sent;
        int          nb;
        int          w;
        logic [63:0] d;
        logic [7:0]  kp;
        sent = 0;
        do begin
            nb = (n - sent > 8) ? 8 : n - sent;
            d  = '0;
            kp = '0;
            for (int k = 0; k < nb; k++) begin
                d[k*8 +: 8] = rd_buf[sent + k];
                kp[k]       = 1'b1;
            end
            s_axis_tdata  = d;
            s_axis_tkeep  = kp;
            s_axis_tlast  = (sent + nb >= n);
            s_axis_tvalid = 1'b1;
            w = 0;
            while (!s_axis_tready && w < BOUND) begin
                @(posedge clk); #1;
                w++;
                stall_cnt++;
            end
            if (w >= BOUND) chk("beat_timeout", 384'(w < BOUND), 384'(1));
            @(posedge clk); #1;
            sent += nb;
        end while (sent < n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic get_word(output logic [READ_DW-1:0] wd);
        int t;
        t = 0;
        m_axis_tready = 1'b1;
        while (!m_axis_tvalid && t < BOUND) begin
            @(posedge clk); #1;
            t++;
        end
        chk("out_wait", 384'(t < BOUND), 384'(1));
        wd = m_axis_tdata;
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
    endtask

    task automatic fill_const(input int n, input logic [7:0] b);
        for (int i = 0; i < n; i++) rd_buf[i] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_tready", s_axis_tready, 1);
        chk("rst_trunc", stat_trunc_cnt, 0);
        chk("rst_short", stat_short_cnt, 0);

        // 76-base ACGT repeat, rid loaded to 100
        rid_base = 32'd100; param_update = 1'b1;
        @(posedge clk); #1;
        param_update = 1'b0;
        for (int i = 0; i < 76; i++) begin
            case (i % 4)
                0: rd_buf[i] = "A";
                1: rd_buf[i] = "C";
                2: rd_buf[i] = "G";
                default: rd_buf[i] = "T";
            endcase
            exp_sym[i] = 4'(i % 4);
        end
        send_buf(76);
        chk("acgt_vld_lat", m_axis_tvalid, 1);
        chk("acgt_rdy_hold", s_axis_tready, 0);
        get_word(word);
        chk("acgt_word", word, mk(32'd100));
        chk("acgt_short", stat_short_cnt, 0);
        chk("acgt_trunc", stat_trunc_cnt, 0);
        chk("acgt_rdy_after", s_axis_tready, 1);

        // 40-base lowercase g read
        fill_const(40, "g");
        for (int i = 0; i < 76; i++) exp_sym[i] = (i < 40) ? 4'd2 : 4'd4;
        send_buf(40);
        get_word(word);
        chk("short_word", word, mk(32'd101));
        chk("short_cnt", stat_short_cnt, 1);

        // 100-base read: 76 T then C overflow
        for (int i = 0; i < 100; i++) rd_buf[i] = (i < 76) ? "T" : "C";
        for (int i = 0; i < 76; i++) exp_sym[i] = 4'd3;
        stall_cnt = 0;
        send_buf(100);
        chk("trunc_stalls", stall_cnt, 0);
        get_word(word);
        chk("trunc_word", word, mk(32'd102));
        chk("trunc_cnt", stat_trunc_cnt, 1);
        chk("trunc_short", stat_short_cnt, 1);

        // three back-to-back reads, consumer holds off 20 cycles each
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 76; i++) exp_sym[i] = 4'(r);
            ew[r] = mk(32'(103 + r));
        end
        fork
            begin
                fill_const(76, "A"); send_buf(76);
                fill_const(76, "C"); send_buf(76);
                fill_const(76, "G"); send_buf(76);
            end
            begin
                for (int r = 0; r < 3; r++) begin
                    logic [READ_DW-1:0] held;
                    int t;
                    t = 0;
                    while (!m_axis_tvalid && t < BOUND) begin
                        @(posedge clk); #1;
                        t++;
                    end
                    chk("b2b_wait", 384'(t < BOUND), 384'(1));
                    held = m_axis_tdata;
                    chk("b2b_word", held, ew[r]);
                    for (int c = 0; c < 20; c++) begin
                        @(posedge clk); #1;
                        if (m_axis_tdata !== held) unst++;
                        if (s_axis_tready) hold_viol++;
                    end
                    m_axis_tready = 1'b1;
                    @(posedge clk); #1;
                    m_axis_tready = 1'b0;
                end
            end
        join
        chk("b2b_stable", unst, 0);
        chk("b2b_no_accept", hold_viol, 0);

        // reset after the third beat of a read
        for (int b = 0; b < 3; b++) begin
            s_axis_tdata = 64'h4141_4141_4141_4141;
            s_axis_tkeep = 8'hFF; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_short", stat_short_cnt, 0);
        chk("mid_rst_trunc", stat_trunc_cnt, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_quiet", m_axis_tvalid, 0);

        // odd bytes plus mixed case, rid restarts at 0
        rd_buf[0] = "N"; rd_buf[1] = "x"; rd_buf[2] = 8'h00; rd_buf[3] = "a";
        rd_buf[4] = "c"; rd_buf[5] = "g"; rd_buf[6] = "t"; rd_buf[7] = "A";
        rd_buf[8] = "C"; rd_buf[9] = "G"; rd_buf[10] = "T"; rd_buf[11] = "n";
        for (int i = 0; i < 76; i++) exp_sym[i] = 4'd4;
        exp_sym[3] = 4'd0; exp_sym[4] = 4'd1; exp_sym[5] = 4'd2; exp_sym[6] = 4'd3;
        exp_sym[7] = 4'd0; exp_sym[8] = 4'd1; exp_sym[9] = 4'd2; exp_sym[10] = 4'd3;
        send_buf(12);
        chk("enc_vld_lat", m_axis_tvalid, 1);
        get_word(word);
        chk("enc_word", word, mk(32'd0));
        chk("enc_short", stat_short_cnt, 1);

        // reload on the handshake cycle: old rid leaves, next rid is rid_base
        fill_const(4, "C");
        for (int i = 0; i < 76; i++) exp_sym[i] = (i < 4) ? 4'd1 : 4'd4;
        send_buf(4);
        rid_base = 32'd500; param_update = 1'b1; m_axis_tready = 1'b1;
        word = m_axis_tdata;
        chk("hs_upd_vld", m_axis_tvalid, 1);
        @(posedge clk); #1;
        param_update = 1'b0; m_axis_tready = 1'b0;
        chk("hs_upd_word", word, mk(32'd1));
        chk("hs_upd_after", m_axis_tvalid, 0);

        // empty tlast beat -> all-N word, then reload while pending
        for (int i = 0; i < 76; i++) exp_sym[i] = 4'd4;
        send_buf(0);
        chk("empty_vld", m_axis_tvalid, 1);
        chk("empty_word", m_axis_tdata, mk(32'd500));
        rid_base = 32'd777; param_update = 1'b1;
        @(posedge clk); #1;
        param_update = 1'b0;
        chk("hold_upd_word", m_axis_tdata, mk(32'd777));
        get_word(word);
        chk("hold_upd_out", word, mk(32'd777));
        chk("final_short", stat_short_cnt, 3);
        chk("final_trunc", stat_trunc_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
